// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 raster constants, counter widths and the
// tracker state encoding shared by the sync receive path.
package vga_timing_pkg;

    localparam int COL_W = 10;
    localparam int ROW_W = 10;
    localparam int PER_W = 12;

    localparam int VGA_TOTAL_COLS   = 800;
    localparam int VGA_TOTAL_ROWS   = 525;
    localparam int VGA_ACTIVE_COLS  = 640;
    localparam int VGA_ACTIVE_ROWS  = 480;
    localparam int VGA_H_PORCH_COLS = VGA_TOTAL_COLS - VGA_ACTIVE_COLS;
    localparam int VGA_V_PORCH_ROWS = VGA_TOTAL_ROWS - VGA_ACTIVE_ROWS;

    typedef enum logic [1:0] {
        SEARCH,
        TRAIN,
        WAIT_V,
        LOCKED
    } track_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: two-flop input pipe with a rising-edge pulse
// taken between the two stages.
module sync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic rise
);

    logic d1;
    logic d2;

    always_ff @(posedge clk) begin
        if (reset) begin
            d1 <= 1'b0;
            d2 <= 1'b0;
        end else begin
            d1 <= sync;
            d2 <= d1;
        end
    end

    assign rise = d1 & ~d2;

endmodule

// File: rtl/vga_sync_tracker.sv
// vga_sync_tracker: flywheel lock to an incoming hsync/vsync pair and
// regeneration of column/row counters, active and frame-start strobes.
module vga_sync_tracker
    import vga_timing_pkg::*;
#(
    parameter int TOTAL_COLS  = VGA_TOTAL_COLS,
    parameter int TOTAL_ROWS  = VGA_TOTAL_ROWS,
    parameter int ACTIVE_COLS = VGA_ACTIVE_COLS,
    parameter int ACTIVE_ROWS = VGA_ACTIVE_ROWS,
    parameter int LOCK_LINES  = 4,
    parameter int MISS_LIMIT  = 3
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_hsync,
    input  logic             i_vsync,
    output logic             o_locked,
    output logic [COL_W-1:0] o_col_count,
    output logic [ROW_W-1:0] o_row_count,
    output logic             o_active,
    output logic             o_frame_start,
    output logic [PER_W-1:0] o_line_period
);

    localparam int H_PORCH_COLS = TOTAL_COLS - ACTIVE_COLS;
    localparam int V_PORCH_ROWS = TOTAL_ROWS - ACTIVE_ROWS;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(TOTAL_COLS - 1);
    localparam logic [COL_W-1:0] COL_PORCH = COL_W'(H_PORCH_COLS);
    localparam logic [COL_W-1:0] COL_CHK   = COL_W'(H_PORCH_COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(TOTAL_ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_PORCH = ROW_W'(V_PORCH_ROWS);
    localparam logic [ROW_W-1:0] ROW_CHK   = ROW_W'(V_PORCH_ROWS - 1);
    localparam logic [PER_W-1:0] PER_LINE  = PER_W'(TOTAL_COLS);
    localparam logic [PER_W-1:0] PER_MAX   = '1;
    localparam logic [3:0]       GOOD_LOCK = 4'(LOCK_LINES);
    localparam logic [3:0]       MISS_MAX  = 4'(MISS_LIMIT);
    localparam logic [11:0]      WAIT_MAX  = 12'(2 * TOTAL_ROWS);

    track_state_t     state;
    track_state_t     state_n;
    logic [COL_W-1:0] col;
    logic [COL_W-1:0] col_n;
    logic [ROW_W-1:0] row;
    logic [ROW_W-1:0] row_n;
    logic [PER_W-1:0] period;
    logic [3:0]       good;
    logic [3:0]       good_n;
    logic [3:0]       miss;
    logic [3:0]       miss_n;
    logic [11:0]      wait_lines;
    logic [11:0]      wait_n;

    logic h_rise;
    logic v_rise;
    logic col_wrap;
    logic h_chk;
    logic h_bad;
    logic v_bad;
    logic per_ovf;

    sync_edge_detect u_hsync_edge (
        .clk   (i_clk),
        .reset (i_reset),
        .sync  (i_hsync),
        .rise  (h_rise)
    );

    sync_edge_detect u_vsync_edge (
        .clk   (i_clk),
        .reset (i_reset),
        .sync  (i_vsync),
        .rise  (v_rise)
    );

    assign col_wrap = (col == COL_LAST);
    assign h_chk    = (col == COL_CHK);
    // Edge off the checkpoint, or checkpoint without an edge.
    assign h_bad    = h_rise ^ h_chk;
    assign v_bad    = v_rise && !((row == ROW_CHK) && col_wrap);
    assign per_ovf  = (period == PER_MAX) && !h_rise;

    always_comb begin
        state_n = state;
        good_n  = good;
        miss_n  = miss;
        wait_n  = wait_lines;
        col_n   = col_wrap ? '0 : col + COL_W'(1);
        row_n   = row;
        if (col_wrap) begin
            row_n = (row == ROW_LAST) ? '0 : row + ROW_W'(1);
        end
        unique case (state)
            SEARCH: begin
                row_n = '0;
                if (h_rise) begin
                    col_n   = COL_PORCH;
                    good_n  = '0;
                    state_n = TRAIN;
                end
            end
            TRAIN: begin
                row_n = '0;
                if (h_rise) begin
                    col_n  = COL_PORCH;
                    good_n = (period == PER_LINE) ? good + 4'd1 : '0;
                    if (good_n == GOOD_LOCK) begin
                        state_n = WAIT_V;
                        wait_n  = '0;
                    end
                end else if (per_ovf) begin
                    state_n = SEARCH;
                    good_n  = '0;
                end
            end
            WAIT_V: begin
                if (col_wrap) begin
                    wait_n = wait_lines + 12'd1;
                end
                if (v_rise) begin
                    row_n   = ROW_PORCH;
                    miss_n  = '0;
                    state_n = LOCKED;
                end else if (h_rise && !h_chk) begin
                    good_n  = '0;
                    state_n = TRAIN;
                end else if (col_wrap && wait_n == WAIT_MAX) begin
                    row_n   = '0;
                    state_n = SEARCH;
                end
            end
            LOCKED: begin
                if (h_bad || v_bad) begin
                    miss_n = miss + 4'd1;
                end else if (h_rise) begin
                    miss_n = '0;
                end
                if (miss_n == MISS_MAX) begin
                    col_n   = '0;
                    row_n   = '0;
                    miss_n  = '0;
                    good_n  = '0;
                    state_n = SEARCH;
                end
            end
            default: state_n = SEARCH;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state         <= SEARCH;
            col           <= '0;
            row           <= '0;
            good          <= '0;
            miss          <= '0;
            wait_lines    <= '0;
            period        <= '0;
            o_line_period <= '0;
            o_active      <= 1'b0;
            o_frame_start <= 1'b0;
        end else begin
            state      <= state_n;
            col        <= col_n;
            row        <= row_n;
            good       <= good_n;
            miss       <= miss_n;
            wait_lines <= wait_n;
            if (h_rise) begin
                o_line_period <= period;
                period        <= PER_W'(1);
            end else if (period != PER_MAX) begin
                period <= period + PER_W'(1);
            end
            o_active <= (state_n == LOCKED)
                     && (col_n >= COL_PORCH)
                     && (row_n >= ROW_PORCH);
            o_frame_start <= (state_n == LOCKED)
                          && (col_n == '0)
                          && (row_n == '0);
        end
    end

    assign o_locked    = (state == LOCKED);
    assign o_col_count = col;
    assign o_row_count = row;

endmodule

// File: tb/tb_vga_sync_tracker.sv
// tb_vga_sync_tracker: directed raster source driving the tracker on a
// scaled-down 80x60 timing so whole frames fit in a short run.
module tb_vga_sync_tracker;

    localparam int C  = 80;
    localparam int R  = 60;
    localparam int AC = 64;
    localparam int AR = 40;
    localparam int HP = C - AC;
    localparam int VP = R - AR;
    localparam int FR = C * R;

    logic       clk;
    logic       i_reset;
    logic       i_hsync;
    logic       i_vsync;
    logic       o_locked;
    logic [9:0] o_col_count;
    logic [9:0] o_row_count;
    logic       o_active;
    logic       o_frame_start;
    logic [11:0] o_line_period;

    vga_sync_tracker #(
        .TOTAL_COLS  (C),
        .TOTAL_ROWS  (R),
        .ACTIVE_COLS (AC),
        .ACTIVE_ROWS (AR),
        .LOCK_LINES  (4),
        .MISS_LIMIT  (3)
    ) dut (
        .i_clk         (clk),
        .i_reset       (i_reset),
        .i_hsync       (i_hsync),
        .i_vsync       (i_vsync),
        .o_locked      (o_locked),
        .o_col_count   (o_col_count),
        .o_row_count   (o_row_count),
        .o_active      (o_active),
        .o_frame_start (o_frame_start),
        .o_line_period (o_line_period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int f;
        int r;
        int c;
        int cnt;
        int lk;
        int act;
        int fs;
        int col;
        int row;
        int lp;
    } vec_t;

    vec_t vecs[10];

    int passed = 0;
    int total  = 0;

    // source position now (sc..), one cycle back (pc..), and the
    // position the DUT outputs must show (dc..)
    int sc, sr, sf, pc, pr, pf, dc, dr, df;
    int len = C;
    int skip_lo = -1;
    int skip_hi = -2;
    int g_row = -1;
    int g_col = -1;
    bit trk_en = 1'b0;
    int trk_bad, fs_cnt, act_cnt;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic drive();
        i_hsync = (sc >= HP) && !(sr >= skip_lo && sr <= skip_hi);
        i_vsync = (sr >= VP) && !(sr == g_row && sc == g_col);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        dc = pc;
        dr = pr;
        df = pf;
        if (trk_en) begin
            if (!o_locked || int'(o_col_count) != dc
                || int'(o_row_count) != dr) trk_bad++;
            if (o_frame_start) begin
                fs_cnt++;
                if (o_col_count != 0 || o_row_count != 0) trk_bad++;
            end
            if (o_active) act_cnt++;
        end
        pc = sc;
        pr = sr;
        pf = sf;
        sc++;
        if (sc >= len) begin
            sc = 0;
            sr++;
            if (sr == R) begin
                sr = 0;
                sf++;
            end
        end
        drive();
    endtask

    task automatic run_to(input int f, input int r, input int c);
        int n;
        n = 0;
        while (!(df == f && dr == r && dc == c) && n < 20000) begin
            tick();
            n++;
        end
        check($sformatf("reach_%0d_%0d_%0d", f, r, c), int'(n < 20000), 1);
    endtask

    task automatic wait_src(input int c, input int r, input int bound);
        int n;
        n = 0;
        while (!(sc == c && (r < 0 || sr == r)) && n < bound) begin
            tick();
            n++;
        end
        check($sformatf("src_%0d_%0d", r, c), int'(n < bound), 1);
    endtask

    task automatic check_zero(input string nm);
        check({nm, "_locked"}, int'(o_locked), 0);
        check({nm, "_col"}, int'(o_col_count), 0);
        check({nm, "_row"}, int'(o_row_count), 0);
        check({nm, "_active"}, int'(o_active), 0);
        check({nm, "_fs"}, int'(o_frame_start), 0);
        check({nm, "_lp"}, int'(o_line_period), 0);
    endtask

    initial begin
        int n;
        int lk;
        int f7;

        vecs[0] = '{0, 0, 50, 1, 0, 0, 0, 50, 0, -1};
        vecs[1] = '{0, 19, 79, 1, 0, 0, 0, 79, 15, 80};
        vecs[2] = '{0, 20, 0, 1, 1, 0, 0, 0, 20, 80};
        vecs[3] = '{0, 20, 15, 1, 1, 0, 0, 15, 20, 80};
        vecs[4] = '{0, 20, 16, 1, 1, 1, 0, 16, 20, 80};
        vecs[5] = '{0, 59, 79, 1, 1, 1, 0, 79, 59, 80};
        vecs[6] = '{1, 0, 0, 1, 1, 0, 1, 0, 0, 80};
        vecs[7] = '{1, 0, 1, 1, 1, 0, 0, 1, 0, 80};
        vecs[8] = '{1, 19, 50, 1, 1, 0, 0, 50, 19, 80};
        vecs[9] = '{1, 20, 50, 1, 1, 1, 0, 50, 20, 80};

        i_reset = 1'b1;
        i_hsync = 1'b0;
        i_vsync = 1'b0;
        pc = -1; pr = -1; pf = -1;
        dc = -1; dr = -1; df = -1;
        repeat (3) @(posedge clk);
        #1;
        i_reset = 1'b0;
        sc = 0; sr = 0; sf = 0;
        drive();
        check_zero("reset");

        for (int i = 0; i < 10; i++) begin
            run_to(vecs[i].f, vecs[i].r, vecs[i].c);
            check($sformatf("v%0d_locked", i), int'(o_locked), vecs[i].lk);
            check($sformatf("v%0d_active", i), int'(o_active), vecs[i].act);
            check($sformatf("v%0d_fs", i), int'(o_frame_start), vecs[i].fs);
            if (vecs[i].cnt != 0) begin
                check($sformatf("v%0d_col", i), int'(o_col_count), vecs[i].col);
                check($sformatf("v%0d_row", i), int'(o_row_count), vecs[i].row);
            end
            if (vecs[i].lp >= 0)
                check($sformatf("v%0d_lp", i), int'(o_line_period), vecs[i].lp);
        end

        trk_bad = 0;
        fs_cnt = 0;
        act_cnt = 0;
        trk_en = 1'b1;
        repeat (2 * FR) tick();
        check("track_2frames_bad", trk_bad, 0);
        check("track_2frames_fs", fs_cnt, 2);
        check("track_2frames_active", act_cnt, 2 * AC * AR);
        check("track_lp", int'(o_line_period), C);

        skip_lo = 25;
        skip_hi = 25;
        run_to(3, 27, 0);
        check("skip1_locked", int'(o_locked), 1);
        check("skip1_flywheel", trk_bad, 0);

        g_row = 30;
        g_col = 40;
        skip_lo = 32;
        skip_hi = 33;
        run_to(3, 36, 0);
        check("vglitch_locked", int'(o_locked), 1);
        check("vglitch_flywheel", trk_bad, 0);
        g_row = -1;
        g_col = -1;

        skip_lo = 40;
        skip_hi = 42;
        run_to(3, 42, 15);
        check("miss3_pre_locked", int'(o_locked), 1);
        check("miss3_pre_flywheel", trk_bad, 0);
        trk_en = 1'b0;
        tick();
        check("miss3_locked", int'(o_locked), 0);
        check("miss3_col", int'(o_col_count), 0);
        check("miss3_row", int'(o_row_count), 0);
        skip_lo = -1;
        skip_hi = -2;

        run_to(4, 20, 0);
        check("relock_locked", int'(o_locked), 1);
        check("relock_col", int'(o_col_count), 0);
        check("relock_row", int'(o_row_count), 20);

        wait_src(0, -1, 200);
        len = C + 1;
        n = 0;
        while (o_locked && n < 400) begin
            tick();
            n++;
        end
        check("len81_lost_within_3_lines", int'(n > 0 && n <= 3 * (C + 1)), 1);
        lk = 0;
        repeat (2 * R * (C + 1)) begin
            tick();
            if (o_locked) lk++;
        end
        check("len81_no_relock", lk, 0);
        check("len81_lp", int'(o_line_period), C + 1);

        wait_src(0, -1, 200);
        len = C;
        wait_src(40, 2, 6000);
        f7 = sf;
        i_reset = 1'b1;
        tick();
        check_zero("midreset");
        i_reset = 1'b0;
        run_to(f7, 19, 79);
        check("midreset_prelock", int'(o_locked), 0);
        run_to(f7, 20, 0);
        check("midreset_locked", int'(o_locked), 1);
        check("midreset_col", int'(o_col_count), 0);
        check("midreset_row", int'(o_row_count), 20);
        check("midreset_lp", int'(o_line_period), C);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
